// File: rtl/sdram_arbiter.sv
// Arbitrates SDRAM command access among the init sequencer, auto-refresh, write and read requesters.
// Refresh has top priority; write/read either alternate (RW_FAIR=1) or write always wins (RW_FAIR=0).
module sdram_arbiter #(
  parameter logic [3:0] NOP_CMD = 4'b0111,
  parameter bit         RW_FAIR = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t state_reg, state_next;
  logic   last_wr_reg;  // 1: last read/write grant was a write
  logic   wr_wins;
  logic [3:0] cmd;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= IDLE;
      last_wr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ARBIT && state_next == WRITE)
        last_wr_reg <= 1'b1;
      else if (state_reg == ARBIT && state_next == READ)
        last_wr_reg <= 1'b0;
    end
  end

  // Tie-break between simultaneous write and read requests.
  assign wr_wins = RW_FAIR ? !last_wr_reg : 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (init_done) state_next = ARBIT;
      ARBIT: begin
        if (aref_req)                  state_next = AREF;
        else if (wr_req && rd_req)     state_next = wr_wins ? WRITE : READ;
        else if (wr_req)               state_next = WRITE;
        else if (rd_req)               state_next = READ;
      end
      AREF:  if (aref_end) state_next = ARBIT;
      WRITE: if (wr_end)   state_next = ARBIT;
      READ:  if (rd_end)   state_next = ARBIT;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    cmd        = NOP_CMD;
    sdram_ba   = 2'b11;
    sdram_addr = 12'hFFF;
    case (state_reg)
      IDLE: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        aref_en    = 1'b1;
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        wr_en      = 1'b1;
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        rd_en      = 1'b1;
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule
